jt5205_seq: RTL and testbench

- Playback sequencer for the jt5205 ADPCM decoder. It fetches packed 4-bit ADPCM samples from a byte-wide sample ROM between a start and an end address, and presents one nibble per sample strobe on din.
- It holds the decoder in reset while idle, prefetches one byte ahead, and supports optional looping.
- Sits between the CPU-side sound latch logic, the shared SDRAM/ROM request port, and jt5205_adpcm.

---
 rtl/jt5205_seq_if.sv | 12 +
 rtl/jt5205_seq.sv | 145 ++++++++++++++
 tb/tb_jt5205_seq.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/jt5205_seq_if.sv
// Byte-wide sample ROM request port between jt5205_seq and the shared SDRAM/ROM arbiter.
interface jt5205_seq_if #(parameter int AW = 16);
    logic [AW-1:0] rom_addr;
    logic          rom_cs;
    logic          rom_ok;
    logic [7:0]    rom_data;

    // Handshake: rom_cs is the request and holds rom_addr constant while high; a cycle with
    // rom_cs and rom_ok both high transfers rom_data. rom_ok is meaningless while rom_cs is low.
    modport master (output rom_addr, rom_cs, input rom_ok, rom_data);
    modport slave  (input rom_addr, rom_cs, output rom_ok, rom_data);
endinterface

// File: rtl/jt5205_seq.sv
// ADPCM playback sequencer: fetches packed nibbles from ROM between start/end addresses,
// prefetches one byte ahead and feeds jt5205_adpcm one nibble per cen_lo.
module jt5205_seq #(
    parameter int AW = 16
) (
    input  logic          rst,
    input  logic          clk,
    input  logic          i_cen_lo,
    input  logic          i_start,
    input  logic          i_stop,
    input  logic          i_loop,
    input  logic [AW-1:0] i_start_addr,
    input  logic [AW-1:0] i_end_addr,
    jt5205_seq_if.master  rom,
    output logic [3:0]    o_din,
    output logic          o_adpcm_rst,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_underrun,
    output logic [1:0]    o_state
);

    typedef enum logic [1:0] {IDLE = 2'd0, PRIME = 2'd1, PLAY = 2'd2} state_t;

    state_t        r_state;
    logic [AW-1:0] r_addr, r_st, r_en, r_rom_addr;
    logic [7:0]    r_nxt;
    logic [3:0]    r_cur_lo, r_din;
    logic          r_nib, r_nxt_v, r_last_f, r_cur_last;
    logic          r_rom_cs, r_stable;
    logic          r_adpcm_rst, r_busy, r_done, r_underrun;
    logic          w_accept;

    // r_stable marks that rom_addr has been on the bus for a full cycle, so an ok left over
    // from a previous requester is never mistaken for our data.
    assign w_accept = r_rom_cs & r_stable & rom.rom_ok;

    assign rom.rom_addr = r_rom_addr;
    assign rom.rom_cs   = r_rom_cs;
    assign o_din        = r_din;
    assign o_adpcm_rst  = r_adpcm_rst;
    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_underrun   = r_underrun;
    assign o_state      = r_state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_addr      <= '0;
            r_st        <= '0;
            r_en        <= '0;
            r_rom_addr  <= '0;
            r_nxt       <= 8'd0;
            r_cur_lo    <= 4'd0;
            r_din       <= 4'd0;
            r_nib       <= 1'b0;
            r_nxt_v     <= 1'b0;
            r_last_f    <= 1'b0;
            r_cur_last  <= 1'b0;
            r_rom_cs    <= 1'b0;
            r_stable    <= 1'b0;
            r_adpcm_rst <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_underrun  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (i_stop) begin
                r_state     <= IDLE;
                r_rom_cs    <= 1'b0;
                r_stable    <= 1'b0;
                r_adpcm_rst <= 1'b1;
                r_din       <= 4'd0;
                r_busy      <= 1'b0;
                r_nxt_v     <= 1'b0;
                r_last_f    <= 1'b0;
                r_cur_last  <= 1'b0;
                r_nib       <= 1'b0;
            end else if (i_start) begin
                // Restart keeps adpcm_rst as is: a running decoder stays live until PRIME ends.
                r_state    <= PRIME;
                r_st       <= i_start_addr;
                r_en       <= i_end_addr;
                r_addr     <= i_start_addr;
                r_underrun <= 1'b0;
                r_nxt_v    <= 1'b0;
                r_last_f   <= 1'b0;
                r_cur_last <= 1'b0;
                r_nib      <= 1'b0;
                r_rom_cs   <= 1'b0;
                r_stable   <= 1'b0;
                r_din      <= 4'd0;
                r_busy     <= 1'b1;
            end else if (r_state != IDLE) begin
                if (w_accept) begin
                    r_nxt    <= rom.rom_data;
                    r_nxt_v  <= 1'b1;
                    r_rom_cs <= 1'b0;
                    r_stable <= 1'b0;
                    r_last_f <= (r_addr == r_en);
                    r_addr   <= r_addr + AW'(1);
                end else if (r_rom_cs) begin
                    r_stable <= 1'b1;
                end else if (!r_nxt_v && !r_last_f) begin
                    r_rom_cs   <= 1'b1;
                    r_rom_addr <= r_addr;
                end

                if (i_cen_lo) begin
                    if (r_nib) begin
                        r_din <= r_cur_lo;
                        r_nib <= 1'b0;
                    end else if (r_state == PLAY && r_cur_last) begin
                        r_nxt_v    <= 1'b0;
                        r_last_f   <= 1'b0;
                        r_cur_last <= 1'b0;
                        r_din      <= 4'd0;
                        if (i_loop) begin
                            r_addr  <= r_st;
                            r_state <= PRIME;
                        end else begin
                            r_state     <= IDLE;
                            r_adpcm_rst <= 1'b1;
                            r_busy      <= 1'b0;
                            r_done      <= 1'b1;
                        end
                    end else if (r_nxt_v) begin
                        r_state     <= PLAY;
                        r_adpcm_rst <= 1'b0;
                        r_cur_lo    <= r_nxt[3:0];
                        r_din       <= r_nxt[7:4];
                        r_cur_last  <= r_last_f;
                        r_nib       <= 1'b1;
                        r_nxt_v     <= 1'b0;
                    end else if (r_state == PLAY) begin
                        r_din      <= 4'd0;
                        r_underrun <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_jt5205_seq.sv
// Bench for jt5205_seq: ROM responder with programmable latency, nibble/request collectors,
// table-driven and random blocks against an address-walk model, plus hand-written corner cases.
module tb_jt5205_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        cen_lo = 1'b0;
    logic        start, stop, loop;
    logic [15:0] start_addr, end_addr;
    logic [3:0]  din;
    logic        adpcm_rst, busy, done, underrun;
    logic [1:0]  state;

    jt5205_seq_if #(.AW(16)) rif();

    jt5205_seq #(.AW(16)) dut (
        .rst(rst), .clk(clk), .i_cen_lo(cen_lo), .i_start(start), .i_stop(stop),
        .i_loop(loop), .i_start_addr(start_addr), .i_end_addr(end_addr), .rom(rif),
        .o_din(din), .o_adpcm_rst(adpcm_rst), .o_busy(busy), .o_done(done),
        .o_underrun(underrun), .o_state(state)
    );

    always #5 clk = ~clk;

    logic [7:0]  rom_mem [0:65535];
    int          total = 0;
    int          bad = 0;
    int          cen_period = 6;
    int          cen_cnt = 0;
    int          resp_lat = 2;
    int          resp_cnt = 0;
    logic        resp_en = 1'b1;
    logic        force_ok = 1'b0;
    logic        ok_r = 1'b0;
    logic        prev_cs = 1'b0;
    int          done_cnt = 0;
    logic [3:0]  act_q[$];
    logic [15:0] req_q[$];
    logic [3:0]  exp_q[$];
    logic [15:0] exp_a[$];

    typedef struct {
        logic [15:0] st;
        logic [15:0] en;
        int          lat;
        int          per;
        logic        exp_ur;
    } vec_t;
    vec_t vecs [6];

    // Sample strobe, one clk wide every cen_period clocks.
    always @(negedge clk) begin
        if (cen_cnt >= cen_period - 1) begin
            cen_lo  = 1'b1;
            cen_cnt = 0;
        end else begin
            cen_lo  = 1'b0;
            cen_cnt = cen_cnt + 1;
        end
    end

    // ROM model: rom_ok rises resp_lat negedges after the request appears.
    always @(negedge clk) begin
        if (rif.rom_cs && resp_en) begin
            resp_cnt = resp_cnt + 1;
            if (resp_cnt >= resp_lat) ok_r = 1'b1;
        end else begin
            resp_cnt = 0;
            ok_r     = 1'b0;
        end
        rif.rom_ok   = ok_r || force_ok;
        rif.rom_data = rom_mem[rif.rom_addr];
    end

    always @(posedge clk) begin
        if (cen_lo) begin
            #1;
            if (din != 4'd0) act_q.push_back(din);
        end
    end

    always @(posedge clk) begin
        #1;
        if (done) done_cnt = done_cnt + 1;
        if (rif.rom_cs && !prev_cs) req_q.push_back(rif.rom_addr);
        prev_cs = rif.rom_cs;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total = total + 1;
        if (act !== expv) begin
            bad = bad + 1;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic pulse_start(input logic [15:0] st, input logic [15:0] en);
        @(negedge clk);
        start_addr = st;
        end_addr   = en;
        start      = 1'b1;
        @(negedge clk);
        start      = 1'b0;
    endtask

    task automatic wait_done(input int base, input string name);
        for (int c = 0; c < 20000 && done_cnt == base; c++) @(negedge clk);
        chk(name, done_cnt > base, 1);
    endtask

    task automatic run_block(input logic [15:0] st, input logic [15:0] en, input int lat,
                             input int per, input logic exp_ur, input string name);
        logic [15:0] a;
        int abase, rbase, dbase, n;
        exp_q.delete();
        exp_a.delete();
        a = st;
        for (int i = 0; i < 65536; i++) begin
            exp_a.push_back(a);
            exp_q.push_back(rom_mem[a][7:4]);
            exp_q.push_back(rom_mem[a][3:0]);
            if (a == en) break;
            a = a + 16'd1;
        end
        resp_lat   = lat;
        cen_period = per;
        abase = act_q.size();
        rbase = req_q.size();
        dbase = done_cnt;
        pulse_start(st, en);
        chk({name, "_ur_clear"}, underrun, 0);
        chk({name, "_busy_start"}, busy, 1);
        wait_done(dbase, {name, "_done_seen"});
        @(negedge clk);
        @(negedge clk);
        chk({name, "_done_once"}, done_cnt - dbase, 1);
        chk({name, "_busy_end"}, busy, 0);
        chk({name, "_arst_end"}, adpcm_rst, 1);
        chk({name, "_underrun"}, underrun, exp_ur);
        chk({name, "_nib_cnt"}, act_q.size() - abase, exp_q.size());
        n = (act_q.size() - abase < exp_q.size()) ? act_q.size() - abase : exp_q.size();
        for (int i = 0; i < n; i++) chk({name, "_nibble"}, act_q[abase + i], exp_q[i]);
        chk({name, "_req_cnt"}, req_q.size() - rbase, exp_a.size());
        n = (req_q.size() - rbase < exp_a.size()) ? req_q.size() - rbase : exp_a.size();
        for (int i = 0; i < n; i++) chk({name, "_req_addr"}, req_q[rbase + i], exp_a[i]);
    endtask

    initial begin
        int abase, rbase, dbase;
        for (int i = 0; i < 65536; i++)
            rom_mem[i] = {4'($urandom_range(1, 15)), 4'($urandom_range(1, 15))};
        rom_mem[16'h0100] = 8'h12;
        rom_mem[16'h0101] = 8'h34;
        rom_mem[16'h0200] = 8'h5A;

        vecs[0] = '{16'h0100, 16'h0101, 2, 6, 1'b0};
        vecs[1] = '{16'h0100, 16'h0101, 40, 8, 1'b1};
        vecs[2] = '{16'h0400, 16'h0403, 1, 4, 1'b0};
        vecs[3] = '{16'hFFFF, 16'h0000, 2, 6, 1'b0};
        vecs[4] = '{16'h0050, 16'h0050, 3, 5, 1'b0};
        vecs[5] = '{16'h1000, 16'h1007, 5, 3, 1'b1};

        rst = 1'b1; start = 1'b0; stop = 1'b0; loop = 1'b0;
        start_addr = '0; end_addr = '0;
        rif.rom_ok = 1'b0; rif.rom_data = 8'd0;
        repeat (3) @(negedge clk);
        chk("rst_rom_addr", rif.rom_addr, 0);
        chk("rst_rom_cs", rif.rom_cs, 0);
        chk("rst_din", din, 0);
        chk("rst_adpcm_rst", adpcm_rst, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_underrun", underrun, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int v = 0; v < 6; v++)
            run_block(vecs[v].st, vecs[v].en, vecs[v].lat, vecs[v].per, vecs[v].exp_ur,
                      $sformatf("vec%0d", v));

        for (int k = 0; k < 6; k++) begin
            logic [15:0] s;
            s = 16'($urandom_range(0, 65535));
            run_block(s, s + 16'($urandom_range(0, 4)), $urandom_range(1, 5),
                      $urandom_range(16, 24), 1'b0, $sformatf("rnd%0d", k));
        end

        // Looping: three passes, loop dropped mid third pass.
        resp_lat = 2; cen_period = 6; loop = 1'b1;
        abase = act_q.size(); dbase = done_cnt;
        pulse_start(16'h0100, 16'h0101);
        for (int c = 0; c < 5000 && act_q.size() - abase < 9; c++) @(negedge clk);
        chk("loop_progress", act_q.size() - abase >= 9, 1);
        chk("loop_no_done", done_cnt - dbase, 0);
        chk("loop_busy", busy, 1);
        loop = 1'b0;
        wait_done(dbase, "loop_done_seen");
        repeat (2) @(negedge clk);
        chk("loop_nib_cnt", act_q.size() - abase, 12);
        for (int i = 0; i < 12 && abase + i < act_q.size(); i++)
            chk("loop_nibble", act_q[abase + i],
                (i % 2 == 0) ? rom_mem[16'h0100 + 16'((i / 2) % 2)][7:4]
                             : rom_mem[16'h0100 + 16'((i / 2) % 2)][3:0]);
        chk("loop_done_once", done_cnt - dbase, 1);

        // Stop with a request outstanding, then a late ok that must be ignored.
        resp_en = 1'b0;
        abase = act_q.size(); dbase = done_cnt;
        pulse_start(16'h0100, 16'h0101);
        for (int c = 0; c < 50 && !rif.rom_cs; c++) @(negedge clk);
        chk("stop_req_seen", rif.rom_cs, 1);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        chk("stop_busy", busy, 0);
        chk("stop_cs", rif.rom_cs, 0);
        chk("stop_arst", adpcm_rst, 1);
        chk("stop_din", din, 0);
        chk("stop_state", state, 0);
        force_ok = 1'b1;
        repeat (3) @(negedge clk);
        force_ok = 1'b0;
        repeat (20) @(negedge clk);
        chk("stop_still_idle", busy, 0);
        chk("stop_cs_after_ok", rif.rom_cs, 0);
        chk("stop_no_nibbles", act_q.size() - abase, 0);
        chk("stop_no_done", done_cnt - dbase, 0);
        resp_en = 1'b1;

        // Start while playing a long block.
        resp_lat = 2; cen_period = 10;
        pulse_start(16'h0300, 16'h030F);
        abase = act_q.size();
        for (int c = 0; c < 5000 && act_q.size() - abase < 4; c++) @(negedge clk);
        chk("rs_progress", act_q.size() - abase >= 4, 1);
        abase = act_q.size(); rbase = req_q.size(); dbase = done_cnt;
        pulse_start(16'h0200, 16'h0200);
        chk("rs_arst_live", adpcm_rst, 0);
        wait_done(dbase, "rs_done_seen");
        repeat (2) @(negedge clk);
        chk("rs_nib_cnt", act_q.size() - abase, 2);
        if (act_q.size() - abase >= 2) begin
            chk("rs_nib_hi", act_q[abase], rom_mem[16'h0200][7:4]);
            chk("rs_nib_lo", act_q[abase + 1], rom_mem[16'h0200][3:0]);
        end
        chk("rs_req_cnt", req_q.size() - rbase, 1);
        if (req_q.size() > rbase) chk("rs_req_addr", req_q[rbase], 16'h0200);
        chk("rs_done_once", done_cnt - dbase, 1);

        // Asynchronous reset mid-underrun with a request pending.
        resp_lat = 40; cen_period = 8;
        pulse_start(16'h0100, 16'h0101);
        for (int c = 0; c < 2000 && !(underrun && rif.rom_cs); c++) @(negedge clk);
        chk("ar_pre_underrun", underrun, 1);
        chk("ar_pre_cs", rif.rom_cs, 1);
        #2 rst = 1'b1;
        #1;
        chk("ar_cs", rif.rom_cs, 0);
        chk("ar_addr", rif.rom_addr, 0);
        chk("ar_arst", adpcm_rst, 1);
        chk("ar_busy", busy, 0);
        chk("ar_din", din, 0);
        chk("ar_underrun", underrun, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
